// File: rtl/sonar_pkg.sv
// Shared types and timing constants for the multi-sensor ultrasonic ranging scheduler.
package sonar_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_TRIG,
      S_WAIT_ECHO,
      S_MEASURE,
      S_GAP
   } state_e;

   // Round-trip echo time per centimetre of range.
   localparam int unsigned US_PER_CM = 58;
   localparam int unsigned CM_W      = 9;

   localparam int unsigned DEF_NUM_SENSORS  = 4;
   localparam int unsigned DEF_CYC_PER_US   = 50;
   localparam int unsigned DEF_TRIG_US      = 10;
   localparam int unsigned DEF_ECHO_WAIT_US = 30000;
   localparam int unsigned DEF_GAP_US       = 60000;
   localparam int unsigned DEF_MAX_CM       = 400;

   // Bits needed for a counter running 0..n-1 (never narrower than one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sonar_if.sv
// Control, sensor pin and result bundle between the scheduler and its surroundings.
interface sonar_if
   import sonar_pkg::*;
#(
   parameter int unsigned NUM_SENSORS = DEF_NUM_SENSORS
);
   localparam int unsigned ID_W = cnt_width(NUM_SENSORS);

   logic                   start;
   logic [NUM_SENSORS-1:0] en_mask;
   logic [NUM_SENSORS-1:0] echo;
   logic [NUM_SENSORS-1:0] trig;
   logic                   busy;
   logic                   res_valid;
   logic [ID_W-1:0]        res_id;
   logic [CM_W-1:0]        res_cm;
   logic                   res_timeout;

   modport master (
      output start, en_mask, echo,
      input  trig, busy, res_valid, res_id, res_cm, res_timeout
   );

   modport slave (
      input  start, en_mask, echo,
      output trig, busy, res_valid, res_id, res_cm, res_timeout
   );

endinterface

// File: rtl/sonar_tick.sv
// Microsecond strobe generator; restart realigns the phase so each state starts a fresh microsecond.
module sonar_tick
   import sonar_pkg::*;
#(
   parameter int unsigned CYC_PER_US = DEF_CYC_PER_US
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick_c
);
   localparam int unsigned      CNT_W = cnt_width(CYC_PER_US);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYC_PER_US - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick_c = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (restart || tick_c) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/measure scheduler for a bank of ultrasonic rangers.
// Echo pins are synchronized; one sensor is serviced at a time, results reported in cm.
module sonar_scheduler
   import sonar_pkg::*;
#(
   parameter int unsigned NUM_SENSORS  = DEF_NUM_SENSORS,
   parameter int unsigned CYC_PER_US   = DEF_CYC_PER_US,
   parameter int unsigned TRIG_US      = DEF_TRIG_US,
   parameter int unsigned ECHO_WAIT_US = DEF_ECHO_WAIT_US,
   parameter int unsigned GAP_US       = DEF_GAP_US,
   parameter int unsigned MAX_CM       = DEF_MAX_CM
) (
   input  logic     clk,
   input  logic     rst_n,
   sonar_if.slave   bus
);
   localparam int unsigned ID_W  = cnt_width(NUM_SENSORS);
   localparam int unsigned MAX_A = (TRIG_US > ECHO_WAIT_US) ? TRIG_US : ECHO_WAIT_US;
   localparam int unsigned MAX_B = (GAP_US > US_PER_CM) ? GAP_US : US_PER_CM;
   localparam int unsigned US_W  = cnt_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

   localparam logic [US_W-1:0] TRIG_LAST = US_W'(TRIG_US - 1);
   localparam logic [US_W-1:0] ECHO_LAST = US_W'(ECHO_WAIT_US - 1);
   localparam logic [US_W-1:0] GAP_LAST  = US_W'(GAP_US - 1);
   localparam logic [US_W-1:0] CM_LAST   = US_W'(US_PER_CM - 1);
   localparam logic [CM_W-1:0] CM_SAT    = CM_W'(MAX_CM);
   localparam logic [ID_W-1:0] ID_LAST   = ID_W'(NUM_SENSORS - 1);

   state_e                 state_q, state_d;
   logic [NUM_SENSORS-1:0] sync1_q, echo_s_q, echo_prev_q;
   logic [ID_W-1:0]        id_q, id_d;
   logic [ID_W-1:0]        rr_q, rr_d;
   logic [US_W-1:0]        us_q, us_d;
   logic [CM_W-1:0]        cm_q, cm_d;
   logic [NUM_SENSORS-1:0] trig_q, trig_d;
   logic                   busy_q, busy_d;
   logic                   res_valid_q, res_valid_d;
   logic [ID_W-1:0]        res_id_q, res_id_d;
   logic [CM_W-1:0]        res_cm_q, res_cm_d;
   logic                   res_timeout_q, res_timeout_d;

   logic                   tick_c;
   logic                   restart_c;
   logic                   any_en_c;
   logic                   echo_c;
   logic                   rise_c;
   logic                   cm_step_c;
   logic [ID_W-1:0]        pick_c;
   logic                   pick_ok_c;

   sonar_tick #(
      .CYC_PER_US (CYC_PER_US)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart_c),
      .tick_c  (tick_c)
   );

   // Two-flop synchronizer plus one history stage for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         echo_s_q    <= '0;
         echo_prev_q <= '0;
      end else begin
         sync1_q     <= bus.echo;
         echo_s_q    <= sync1_q;
         echo_prev_q <= echo_s_q;
      end
   end

   assign any_en_c  = |bus.en_mask;
   assign echo_c    = echo_s_q[id_q];
   assign rise_c    = echo_s_q[id_q] & ~echo_prev_q[id_q];
   assign cm_step_c = tick_c && (us_q == CM_LAST);

   // Next enabled sensor strictly after the last one served, wrapping around.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      pick_c    = rr_q;
      pick_ok_c = 1'b0;
      for (int unsigned k = 1; k <= NUM_SENSORS; k++) begin
         idx = (32'(rr_q) + k) % NUM_SENSORS;
         if (!pick_ok_c && bus.en_mask[ID_W'(idx)]) begin
            pick_c    = ID_W'(idx);
            pick_ok_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         id_q          <= '0;
         rr_q          <= ID_LAST;
         us_q          <= '0;
         cm_q          <= '0;
         trig_q        <= '0;
         busy_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_cm_q      <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         id_q          <= id_d;
         rr_q          <= rr_d;
         us_q          <= us_d;
         cm_q          <= cm_d;
         trig_q        <= trig_d;
         busy_q        <= busy_d;
         res_valid_q   <= res_valid_d;
         res_id_q      <= res_id_d;
         res_cm_q      <= res_cm_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      id_d          = id_q;
      rr_d          = rr_q;
      us_d          = us_q;
      cm_d          = cm_q;
      trig_d        = '0;
      busy_d        = 1'b0;
      restart_c     = 1'b0;
      res_valid_d   = 1'b0;
      res_id_d      = res_id_q;
      res_cm_d      = res_cm_q;
      res_timeout_d = res_timeout_q;

      if (tick_c) begin
         us_d = us_q + US_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.start && any_en_c) begin
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            if (pick_ok_c) begin
               id_d    = pick_c;
               rr_d    = pick_c;
               state_d = S_TRIG;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_TRIG: begin
            if (tick_c && (us_q == TRIG_LAST)) begin
               state_d = S_WAIT_ECHO;
            end
         end
         S_WAIT_ECHO: begin
            if (rise_c) begin
               cm_d    = '0;
               state_d = S_MEASURE;
            end else if (tick_c && (us_q == ECHO_LAST)) begin
               res_valid_d   = 1'b1;
               res_id_d      = id_q;
               res_cm_d      = '0;
               res_timeout_d = 1'b1;
               state_d       = S_GAP;
            end
         end
         S_MEASURE: begin
            // The fall-detect cycle still counts as echo time (matches the rise-detect delay).
            if (!echo_c) begin
               res_valid_d   = 1'b1;
               res_id_d      = id_q;
               res_cm_d      = cm_q + CM_W'(cm_step_c);
               res_timeout_d = 1'b0;
               state_d       = S_GAP;
            end else if (cm_step_c && ((cm_q + CM_W'(1)) == CM_SAT)) begin
               res_valid_d   = 1'b1;
               res_id_d      = id_q;
               res_cm_d      = CM_SAT;
               res_timeout_d = 1'b1;
               state_d       = S_GAP;
            end else if (cm_step_c) begin
               cm_d = cm_q + CM_W'(1);
               us_d = '0;
            end
         end
         S_GAP: begin
            if (tick_c && (us_q == GAP_LAST)) begin
               state_d = (bus.start && any_en_c) ? S_SELECT : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      restart_c = (state_d != state_q);
      if (restart_c) begin
         us_d = '0;
      end
      trig_d = (state_d == S_TRIG) ? (NUM_SENSORS'(1) << id_d) : '0;
      busy_d = (state_d != S_IDLE);
   end

   assign bus.trig        = trig_q;
   assign bus.busy        = busy_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_id      = res_id_q;
   assign bus.res_cm      = res_cm_q;
   assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Scoreboard bench for sonar_scheduler: stimulus queues expected triggers/results, a monitor checks them.
module tb_sonar_scheduler;
   import sonar_pkg::*;

   localparam int unsigned NS    = 4;
   localparam int          BOUND = 3000;

   typedef struct {
      int id;
      int cm;
      int to;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sonar_if #(.NUM_SENSORS(NS)) bus ();

   sonar_scheduler #(
      .NUM_SENSORS  (NS),
      .CYC_PER_US   (1),
      .TRIG_US      (10),
      .ECHO_WAIT_US (300),
      .GAP_US       (100),
      .MAX_CM       (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   res_t exp_res[$];
   int   exp_trig[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expired(input string name);
      tests++;
      fails++;
      $display("FAIL %s: no event within %0d cycles (cycle %0d)", name, BOUND, cyc);
   endtask

   // Monitor: trigger order/width/one-hot and result scoreboard.
   int tw    = 0;
   bit multi = 1'b0;
   always @(negedge clk) begin
      res_t r;
      int   id;
      if (!rst_n) begin
         tw    = 0;
         multi = 1'b0;
      end else begin
         if (bus.res_valid) begin
            if (exp_res.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_res: got id %0d cm %0d to %0d, expected none",
                        bus.res_id, bus.res_cm, bus.res_timeout);
            end else begin
               r = exp_res.pop_front();
               check("res_id", int'(bus.res_id), r.id);
               check("res_cm", int'(bus.res_cm), r.cm);
               check("res_timeout", int'(bus.res_timeout), r.to);
            end
         end
         if (bus.trig != '0) begin
            if (tw == 0) begin
               id = -1;
               for (int i = 0; i < int'(NS); i++) if (bus.trig[i]) id = i;
               if (exp_trig.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_trig: got sensor %0d, expected none", id);
               end else begin
                  check("trig_id", id, exp_trig.pop_front());
               end
            end
            tw++;
            if ($countones(bus.trig) > 1) multi = 1'b1;
         end else if (tw != 0) begin
            check("trig_width", tw, 10);
            check("trig_onehot", int'(multi), 0);
            tw    = 0;
            multi = 1'b0;
         end
      end
   end

   task automatic push_res(input int id, input int cm, input int to);
      res_t r;
      r.id = id;
      r.cm = cm;
      r.to = to;
      exp_res.push_back(r);
   endtask

   task automatic wait_trig_fall(output int sid, output int t);
      int n = 0;
      sid = 0;
      while (bus.trig == '0 && n < BOUND) begin @(negedge clk); n++; end
      for (int i = 0; i < int'(NS); i++) if (bus.trig[i]) sid = i;
      while (bus.trig != '0 && n < BOUND) begin @(negedge clk); n++; end
      if (n >= BOUND) expired("trig_fall");
      t = cyc;
   endtask

   task automatic wait_res(output int t);
      int n = 0;
      while (!bus.res_valid && n < BOUND) begin @(negedge clk); n++; end
      if (!bus.res_valid) expired("res_valid");
      t = cyc;
   endtask

   task automatic wait_idle(output int t);
      int n = 0;
      while (bus.busy && n < BOUND) begin @(negedge clk); n++; end
      if (bus.busy) expired("idle");
      t = cyc;
   endtask

   task automatic echo_pulse(input int sid, input int delay, input int width);
      repeat (delay) @(negedge clk);
      bus.echo[2'(sid)] = 1'b1;
      repeat (width) @(negedge clk);
      bus.echo[2'(sid)] = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_trig"}, int'(bus.trig), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_res_valid"}, int'(bus.res_valid), 0);
      check({tag, "_res_id"}, int'(bus.res_id), 0);
      check({tag, "_res_cm"}, int'(bus.res_cm), 0);
      check({tag, "_res_timeout"}, int'(bus.res_timeout), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
      $fatal(1);
   end

   initial begin
      int sid, tf, tf2, tr, tr2, ti, tc;
      bus.start   = 1'b0;
      bus.en_mask = '0;
      bus.echo    = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single sensor, 580 us echo -> 10 cm.
      bus.en_mask = 4'b0001;
      bus.start   = 1'b1;
      exp_trig.push_back(0);
      push_res(0, 10, 0);
      wait_trig_fall(sid, tf);
      echo_pulse(0, 20, 580);
      tc = cyc;
      wait_res(tr);
      check("echo_fall_to_valid", tr - tc, 3);
      bus.start = 1'b0;
      wait_idle(ti);
      check("gap_len", ti - tr, 100);
      check("idle_busy", int'(bus.busy), 0);

      // Round robin over sensors 1 and 3, with a stray echo on sensor 3 first.
      bus.en_mask = 4'b1010;
      bus.start   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_trig.push_back((k % 2 == 0) ? 1 : 3);
         push_res((k % 2 == 0) ? 1 : 3, 2, 0);
      end
      for (int k = 0; k < 4; k++) begin
         wait_trig_fall(sid, tf);
         if (k == 3) bus.start = 1'b0;
         if (k == 0) begin
            echo_pulse(3, 2, 30);
            echo_pulse(sid, 10, 116);
         end else begin
            echo_pulse(sid, 5, 116);
         end
         wait_res(tr);
      end
      wait_idle(ti);

      // No echo -> timeout results, next trigger after the gap.
      bus.en_mask = 4'b0100;
      bus.start   = 1'b1;
      exp_trig.push_back(2);
      push_res(2, 0, 1);
      exp_trig.push_back(2);
      push_res(2, 0, 1);
      wait_trig_fall(sid, tf);
      wait_res(tr);
      check("timeout_latency", tr - tf, 300);
      wait_trig_fall(sid, tf2);
      check("gap_to_next_trig_fall", tf2 - tr, 111);
      bus.start = 1'b0;
      wait_res(tr);
      wait_idle(ti);

      // Reset in MEASURE, then restart from the lowest enabled sensor.
      bus.en_mask = 4'b1011;
      bus.start   = 1'b1;
      exp_trig.push_back(3);
      wait_trig_fall(sid, tf);
      repeat (5) @(negedge clk);
      bus.echo[3] = 1'b1;
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("midreset");
      bus.echo = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_trig.push_back(0);
      push_res(0, 3, 0);
      wait_trig_fall(sid, tf);
      bus.start = 1'b0;
      echo_pulse(0, 10, 174);
      wait_res(tr);
      wait_idle(ti);
      check("stop_idle_busy", int'(bus.busy), 0);
      repeat (50) @(negedge clk);

      // Echo held high: saturate at MAX_CM, then retrigger while echo still high.
      bus.en_mask = 4'b0001;
      bus.start   = 1'b1;
      exp_trig.push_back(0);
      push_res(0, 20, 1);
      exp_trig.push_back(0);
      push_res(0, 0, 1);
      wait_trig_fall(sid, tf);
      repeat (5) @(negedge clk);
      bus.echo[0] = 1'b1;
      tc = cyc;
      wait_res(tr);
      check("sat_latency", tr - tc, 1163);
      wait_trig_fall(sid, tf2);
      check("sat_next_trig_fall", tf2 - tr, 111);
      bus.start = 1'b0;
      wait_res(tr2);
      check("sat_then_timeout", tr2 - tf2, 300);
      bus.echo[0] = 1'b0;
      wait_idle(ti);
      repeat (20) @(negedge clk);

      check("exp_res_drained", exp_res.size(), 0);
      check("exp_trig_drained", exp_trig.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 4, number of ultrasonic rangers served.
REQ-002 Parameter CYC_PER_US, default 50, Clock cycles per microsecond (50 MHz board clock).
REQ-003 Parameter TRIG_US, default 10, trigger pulse width in us.
REQ-004 Parameter ECHO_WAIT_US, default 30000, max wait from trig fall to echo rise.
REQ-005 Parameter GAP_US, default 60000, quiet time after each measurement before the next trigger.
REQ-006 Parameter MAX_CM, default 400, distance saturation value.
REQ-007 Clock  input  1  single system clock, all logic on rising edge.
REQ-008 Reset_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  level; while high the scheduler runs continuously.
REQ-010 en_mask  input  NUM_SENSORS  per-sensor enable; sampled only when selecting the next sensor.
REQ-011 echo  input  NUM_SENSORS  raw asynchronous echo pins.
REQ-012 trig  output  NUM_SENSORS  trigger pins, at most one high at any time.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 res_valid  output  1  one-cycle result strobe.
REQ-015 res_id  output  clog2(NUM_SENSORS)  sensor index of the result.
REQ-016 res_cm  output  9  distance in cm, held until next res_valid.
REQ-017 res_timeout  output  1  result is invalid/saturated, held with res_cm.

Function
REQ-018 Each echo bit SHALL pass through a 2-flop synchronizer; all echo decisions use synchronized values.
REQ-019 A microsecond tick SHALL pulse once every CYC_PER_US cycles, restarted on every state entry.
REQ-020 FSM states SHALL be IDLE, SELECT, TRIG, WAIT_ECHO, MEASURE, GAP.
REQ-021 IDLE -> SELECT when start=1 and en_mask nonzero; otherwise stay IDLE.
REQ-022 SELECT SHALL pick the next enabled index after the last served one (round robin, wrap NUM_SENSORS-1 -> 0; first pick after reset is lowest enabled index) and enter TRIG next cycle.
REQ-023 TRIG SHALL drive trig[id] high for exactly TRIG_US*CYC_PER_US cycles, then WAIT_ECHO.
REQ-024 WAIT_ECHO -> MEASURE on synchronized echo[id] rising; after ECHO_WAIT_US without rise SHALL emit result res_cm=0, res_timeout=1, then GAP.
REQ-025 MEASURE SHALL increment a cm counter every 58 us of echo high, giving res_cm=floor(echo_us/58).
REQ-026 On synchronized echo fall in MEASURE, SHALL emit res_cm=count, res_timeout=0, then GAP.
REQ-027 If the cm counter reaches MAX_CM while echo is high, SHALL emit res_cm=MAX_CM, res_timeout=1 immediately, then GAP (no wait for echo fall).
REQ-028 res_valid SHALL occur 1 cycle after the synchronized event, i.e. 3 Clock edges after the echo pin fall is first sampled.
REQ-029 GAP SHALL last GAP_US; then SELECT if start=1 and en_mask nonzero, else IDLE.
REQ-030 start falling mid-cycle SHALL NOT abort; the current measurement and GAP complete.
REQ-031 en_mask changes mid-cycle SHALL NOT affect the sensor in service.
REQ-032 Echo on non-selected sensors SHALL be ignored.

Reset
REQ-033 Reset_n low SHALL asynchronously force IDLE, trig=0, busy=0, res_valid=0, res_id=0, res_cm=0, res_timeout=0, counters and synchronizers 0, round-robin pointer to NUM_SENSORS-1.
REQ-034 Reset asserted mid-TRIG SHALL drop trig within the same reset assertion, no glitch after release.

Structure
REQ-035 Package sonar_pkg SHALL hold the state enum, the 58 us/cm constant and default timing constants.
REQ-036 Sub-module sonar_tick SHALL implement the restartable microsecond tick generator; synchronizer and FSM stay in sonar_scheduler.

Verification (CYC_PER_US=1, TRIG_US=10, ECHO_WAIT_US=300, GAP_US=100, MAX_CM=20)
REQ-037 start=1, en_mask=4'b0001, echo[0] high for 580 cycles after 20 cycles -> trig[0] high exactly 10 cycles, res_valid once, res_id=0, res_cm=10, res_timeout=0.
REQ-038 en_mask=4'b1010, echoes of 116 us each -> trig order 1,3,1,3, res_cm=2 each, never two trig bits high.
REQ-039 No echo -> res_valid 300 cycles after trig fall with res_cm=0, res_timeout=1, then GAP of 100 cycles.
REQ-040 echo held high 2000 cycles -> res_cm=20, res_timeout=1 at 1160 us of echo, next trig after GAP despite echo still high.
REQ-041 Reset_n pulsed low during MEASURE -> all outputs 0 immediately; after release with start=1 first trig goes to lowest enabled sensor.
REQ-042 start dropped during WAIT_ECHO -> measurement completes, one res_valid, then IDLE with busy=0.
